mem_scan_display: RTL and testbench

- Parametrised readout block that steps through a region of data memory after the RISC core finishes a run, such as a sorted array, and drives one display-width slice at a time onto the board output.
- Successor to the fixed 16-bit, next-only, button-stepped readout.
- Adds the following over that readout:
  - parametrised word, display and address widths;
  - multi-slice display of words wider than the output;
  - forward and backward stepping;
  - built-in debounce;
  - a memory read handshake with timeout.

---
 rtl/mem_scan_display_if.sv | 28 ++
 rtl/mem_scan_display.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_scan_display.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_scan_display_if.sv
// Memory read bus between the scan/display block and data memory.
//   mem_rd_en : one-cycle read request (master -> memory)
//   mem_addr  : read address, valid while mem_rd_en is high (master -> memory)
//   mem_rdata : read data, sampled when mem_valid is high (memory -> master)
//   mem_valid : read data valid, one or more cycles after the request (memory -> master)
interface mem_scan_display_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata,
    input  mem_valid
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata,
    output mem_valid
  );
endinterface

// File: rtl/mem_scan_display.sv
// Readout block: after the core signals done (start 0->1), fetches words of a
// memory region one at a time and shows them OUT_W bits at a time on the board
// output, stepping forward/backward with two debounced push buttons.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   start     : level, 0->1 transition begins readout
//   btn_next  : raw push button, step forward
//   btn_prev  : raw push button, step backward
//   mem       : memory read bus (master side)
//   out       : displayed slice of the current word
//   word_idx  : index of the current word within the region
//   slice_idx : index of the current slice within the word (0 = LSBs)
//   busy      : high while a word is being fetched
//   err       : sticky read-timeout flag, cleared by the next start
module mem_scan_display #(
  parameter int DATA_W     = 32,
  parameter int OUT_W      = 16,
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0,
  parameter int COUNT      = 10,
  parameter int DEB_CYCLES = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               btn_next,
  input  logic               btn_prev,
  mem_scan_display_if.master mem,
  output logic [OUT_W-1:0]   out,
  output logic [ADDR_W-1:0]  word_idx,
  output logic [7:0]         slice_idx,
  output logic               busy,
  output logic               err
);

  localparam int NSLICE = DATA_W / OUT_W;
  localparam int DW     = $clog2(DEB_CYCLES) + 1;
  localparam int TW     = $clog2(TIMEOUT + 1) + 1;

  localparam logic [7:0]        LAST_SLICE = 8'(NSLICE - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    SHOW
  } state_t;

  // Bit order in the synchroniser vectors: {prev, next, start}
  logic [2:0]    sync1, sync2;
  logic [1:0]    filt, filt_d;
  logic [DW-1:0] deb_cnt [2];
  logic          start_d;
  logic          start_p, next_p, prev_p;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [7:0]        slice_q, slice_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;

  // Two-flop synchronisers for the three asynchronous inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_prev, btn_next, start};
      sync2 <= sync1;
    end
  end

  // Button debounce: the filtered level follows the synchronised level only
  // after DEB_CYCLES consecutive samples disagree with it; any agreeing sample
  // restarts the count, so short glitches never get through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt       <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i+1] != filt[i]) begin
          if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
            filt[i]    <= sync2[i+1];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Registered rising-edge pulses; start uses its synchronised level directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_d <= 1'b0;
      filt_d  <= '0;
      start_p <= 1'b0;
      next_p  <= 1'b0;
      prev_p  <= 1'b0;
    end else begin
      start_d <= sync2[0];
      filt_d  <= filt;
      start_p <= sync2[0] & ~start_d;
      next_p  <= filt[0] & ~filt_d[0];
      prev_p  <= filt[1] & ~filt_d[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      word_idx_q <= '0;
      slice_q    <= '0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      word_idx_q <= word_idx_d;
      slice_q    <= slice_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
    end
  end

  // Next-state and stepping logic. Button pulses only act in SHOW, so presses
  // during a fetch are simply lost; start in SHOW outranks the buttons.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    word_idx_d    = word_idx_q;
    slice_d       = slice_q;
    err_d         = err_q;
    tcnt_d        = tcnt_q;
    mem.mem_rd_en = 1'b0;
    busy          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_p) begin
          word_idx_d = '0;
          slice_d    = '0;
          err_d      = 1'b0;
          state_d    = FETCH;
        end
      end

      FETCH: begin
        mem.mem_rd_en = 1'b1;
        busy          = 1'b1;
        tcnt_d        = '0;
        state_d       = WAIT;
      end

      WAIT: begin
        busy = 1'b1;
        if (mem.mem_valid) begin
          word_d  = mem.mem_rdata;
          state_d = SHOW;
        end else if (tcnt_q == TW'(TIMEOUT)) begin
          err_d   = 1'b1;
          word_d  = '1;
          state_d = SHOW;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      SHOW: begin
        if (start_p) begin
          word_idx_d = '0;
          slice_d    = '0;
          err_d      = 1'b0;
          state_d    = FETCH;
        end else if (next_p && !prev_p) begin
          if (slice_q < LAST_SLICE) begin
            slice_d = slice_q + 8'd1;
          end else begin
            slice_d    = '0;
            word_idx_d = (word_idx_q == LAST_WORD) ? '0 : word_idx_q + ADDR_W'(1);
            state_d    = FETCH;
          end
        end else if (prev_p && !next_p) begin
          if (slice_q > 8'd0) begin
            slice_d = slice_q - 8'd1;
          end else begin
            slice_d    = LAST_SLICE;
            word_idx_d = (word_idx_q == '0) ? LAST_WORD : word_idx_q - ADDR_W'(1);
            state_d    = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Slice mux: picks the OUT_W-wide field selected by slice_idx.
  always_comb begin
    out = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (slice_q == 8'(i)) begin
        out = word_q[i*OUT_W +: OUT_W];
      end
    end
  end

  assign mem.mem_addr = ADDR_W'(BASE_ADDR) + word_idx_q;
  assign word_idx     = word_idx_q;
  assign slice_idx    = slice_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_scan_display.sv
// Testbench for mem_scan_display. Two instances: a 16/16 one (COUNT=4,
// BASE_ADDR=100, 1-cycle memory) and a 32/16 one (COUNT=3, BASE_ADDR=0,
// 2-cycle memory). Each test task drives stimulus and checks inline.
module tb_mem_scan_display;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start16, next16, prev16;
  logic start32, next32, prev32;

  logic [15:0] out16, out32;
  logic [9:0]  widx16, widx32;
  logic [7:0]  sidx16, sidx32;
  logic        busy16, busy32, err16, err32;

  mem_scan_display_if #(.DATA_W(16), .ADDR_W(10)) bus16 ();
  mem_scan_display_if #(.DATA_W(32), .ADDR_W(10)) bus32 ();

  mem_scan_display #(
    .DATA_W(16), .OUT_W(16), .ADDR_W(10), .BASE_ADDR(100),
    .COUNT(4), .DEB_CYCLES(8), .TIMEOUT(15)
  ) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .btn_next(next16), .btn_prev(prev16),
    .mem(bus16), .out(out16), .word_idx(widx16), .slice_idx(sidx16),
    .busy(busy16), .err(err16)
  );

  mem_scan_display #(
    .DATA_W(32), .OUT_W(16), .ADDR_W(10), .BASE_ADDR(0),
    .COUNT(3), .DEB_CYCLES(8), .TIMEOUT(15)
  ) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .btn_next(next32), .btn_prev(prev32),
    .mem(bus32), .out(out32), .word_idx(widx32), .slice_idx(sidx32),
    .busy(busy32), .err(err32)
  );

  // Memory models
  logic [15:0] mem16 [0:1023];
  logic [31:0] mem32 [0:1023];
  logic        mem16_en = 1'b1;
  logic        mem32_en = 1'b1;
  logic        mv16 = 1'b0;
  logic [15:0] md16 = '0;
  logic        inj16_valid = 1'b0;
  logic [15:0] inj16_data = '0;
  logic        st32_v = 1'b0;
  logic [9:0]  st32_a = '0;
  logic        mv32 = 1'b0;
  logic [31:0] md32 = '0;

  // 1-cycle memory for the 16-bit instance
  always @(posedge clk) begin
    mv16 <= 1'b0;
    if (bus16.mem_rd_en && mem16_en) begin
      mv16 <= 1'b1;
      md16 <= mem16[bus16.mem_addr];
    end
  end
  assign bus16.mem_valid = mv16 | inj16_valid;
  assign bus16.mem_rdata = inj16_valid ? inj16_data : md16;

  // 2-cycle memory for the 32-bit instance
  always @(posedge clk) begin
    st32_v <= bus32.mem_rd_en && mem32_en;
    st32_a <= bus32.mem_addr;
    mv32   <= st32_v;
    if (st32_v) md32 <= mem32[st32_a];
  end
  assign bus32.mem_valid = mv32;
  assign bus32.mem_rdata = md32;

  // Read request monitors
  int         rd16 = 0;
  int         rd32 = 0;
  logic [9:0] last_addr16 = '0;
  always @(posedge clk) begin
    if (bus16.mem_rd_en) begin
      rd16        <= rd16 + 1;
      last_addr16 <= bus16.mem_addr;
    end
    if (bus32.mem_rd_en) rd32 <= rd32 + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds the selected buttons for 'hold' cycles, then releases long enough
  // for the debouncer to settle back to 0.
  task automatic press(input bit sel32, input bit nx, input bit pv, input int hold);
    @(negedge clk);
    if (sel32) begin next32 = nx; prev32 = pv; end
    else       begin next16 = nx; prev16 = pv; end
    tick(hold);
    next16 = 1'b0; prev16 = 1'b0; next32 = 1'b0; prev32 = 1'b0;
    tick(24);
  endtask

  task automatic do_start(input bit sel32);
    @(negedge clk);
    if (sel32) start32 = 1'b0; else start16 = 1'b0;
    tick(4);
    if (sel32) start32 = 1'b1; else start16 = 1'b1;
    tick(12);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start16 = 0; next16 = 0; prev16 = 0;
    start32 = 0; next32 = 0; prev32 = 0;
    tick(2);
    n_cmp++;
    if ({out16, widx16, sidx16, busy16, err16, bus16.mem_rd_en, bus16.mem_addr} !==
        {16'd0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 10'd100}) begin
      n_bad++;
      $display("[TB] FAIL reset16: got out=%0h widx=%0d sidx=%0d busy=%0b err=%0b rd=%0b addr=%0d, expected zeros with addr=100",
               out16, widx16, sidx16, busy16, err16, bus16.mem_rd_en, bus16.mem_addr);
    end
    n_cmp++;
    if ({out32, widx32, sidx32, busy32, err32, bus32.mem_rd_en, bus32.mem_addr} !==
        {16'd0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 10'd0}) begin
      n_bad++;
      $display("[TB] FAIL reset32: got out=%0h widx=%0d sidx=%0d busy=%0b err=%0b rd=%0b addr=%0d, expected all zero",
               out32, widx32, sidx32, busy32, err32, bus32.mem_rd_en, bus32.mem_addr);
    end
    rst = 1'b1;
    tick(3);
  endtask

  // Start edge to valid output is 2+1+1+1+1 = 6 cycles with a 1-cycle memory.
  task automatic test_start_latency;
    int rd0;
    rd0 = rd16;
    @(negedge clk);
    start16 = 1'b1;
    tick(5);
    n_cmp++;
    if (busy16 !== 1'b1 || out16 !== 16'd0) begin
      n_bad++;
      $display("[TB] FAIL start_wait: got busy=%0b out=%0h, expected busy=1 out=0", busy16, out16);
    end
    tick(1);
    n_cmp++;
    if (out16 !== 16'd7 || widx16 !== 10'd0 || busy16 !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL start_out: got out=%0h widx=%0d busy=%0b, expected out=7 widx=0 busy=0", out16, widx16, busy16);
    end
    n_cmp++;
    if (rd16 - rd0 !== 1) begin
      n_bad++;
      $display("[TB] FAIL start_reads: got %0d, expected 1", rd16 - rd0);
    end
  endtask

  task automatic test_next_wrap;
    logic [15:0] exp_out [4];
    int rd0;
    exp_out[0] = 16'd3; exp_out[1] = 16'd9; exp_out[2] = 16'd1; exp_out[3] = 16'd7;
    for (int i = 0; i < 4; i++) begin
      rd0 = rd16;
      press(1'b0, 1'b1, 1'b0, 20);
      n_cmp++;
      if (out16 !== exp_out[i] || widx16 !== 10'((i + 1) % 4) || rd16 - rd0 !== 1) begin
        n_bad++;
        $display("[TB] FAIL next_step%0d: got out=%0h widx=%0d reads=%0d, expected out=%0h widx=%0d reads=1",
                 i, out16, widx16, rd16 - rd0, exp_out[i], (i + 1) % 4);
      end
    end
  endtask

  task automatic test_prev_wrap;
    int rd0;
    rd0 = rd16;
    press(1'b0, 1'b0, 1'b1, 20);
    n_cmp++;
    if (widx16 !== 10'd3 || out16 !== 16'd1 || rd16 - rd0 !== 1) begin
      n_bad++;
      $display("[TB] FAIL prev_wrap: got widx=%0d out=%0h reads=%0d, expected widx=3 out=1 reads=1", widx16, out16, rd16 - rd0);
    end
    n_cmp++;
    if (last_addr16 !== 10'd103) begin
      n_bad++;
      $display("[TB] FAIL prev_addr: got %0d, expected 103", last_addr16);
    end
  endtask

  task automatic test_bounce;
    int rd0;
    rd0 = rd16;
    repeat (5) begin
      @(negedge clk);
      next16 = 1'b1;
      tick(3);
      next16 = 1'b0;
      tick(3);
    end
    tick(20);
    n_cmp++;
    if (widx16 !== 10'd3 || out16 !== 16'd1 || rd16 != rd0) begin
      n_bad++;
      $display("[TB] FAIL bounce: got widx=%0d out=%0h reads=%0d, expected widx=3 out=1 reads=0", widx16, out16, rd16 - rd0);
    end
    press(1'b0, 1'b1, 1'b0, 20);
    n_cmp++;
    if (widx16 !== 10'd0 || out16 !== 16'd7 || rd16 - rd0 !== 1) begin
      n_bad++;
      $display("[TB] FAIL clean_press: got widx=%0d out=%0h reads=%0d, expected widx=0 out=7 reads=1", widx16, out16, rd16 - rd0);
    end
    rd0 = rd16;
    press(1'b0, 1'b1, 1'b1, 20);
    n_cmp++;
    if (widx16 !== 10'd0 || out16 !== 16'd7 || rd16 != rd0) begin
      n_bad++;
      $display("[TB] FAIL both_buttons: got widx=%0d out=%0h reads=%0d, expected widx=0 out=7 reads=0", widx16, out16, rd16 - rd0);
    end
  endtask

  task automatic test_slices;
    int rd0;
    logic [31:0] w1;
    mem32[0] = 32'hDEAD_BEEF;
    mem32[1] = $urandom;
    mem32[2] = $urandom;
    w1 = mem32[1];
    do_start(1'b1);
    n_cmp++;
    if (out32 !== 16'hBEEF || widx32 !== 10'd0 || sidx32 !== 8'd0) begin
      n_bad++;
      $display("[TB] FAIL slice_start: got out=%0h widx=%0d sidx=%0d, expected beef/0/0", out32, widx32, sidx32);
    end
    rd0 = rd32;
    press(1'b1, 1'b1, 1'b0, 20);
    n_cmp++;
    if (out32 !== 16'hDEAD || sidx32 !== 8'd1 || rd32 != rd0) begin
      n_bad++;
      $display("[TB] FAIL slice_next: got out=%0h sidx=%0d reads=%0d, expected dead/1/0", out32, sidx32, rd32 - rd0);
    end
    press(1'b1, 1'b1, 1'b0, 20);
    n_cmp++;
    if (out32 !== w1[15:0] || widx32 !== 10'd1 || sidx32 !== 8'd0 || rd32 - rd0 !== 1) begin
      n_bad++;
      $display("[TB] FAIL slice_word1: got out=%0h widx=%0d sidx=%0d reads=%0d, expected %0h/1/0/1",
               out32, widx32, sidx32, rd32 - rd0, w1[15:0]);
    end
    press(1'b1, 1'b0, 1'b1, 20);
    n_cmp++;
    if (out32 !== 16'hDEAD || widx32 !== 10'd0 || sidx32 !== 8'd1 || rd32 - rd0 !== 2) begin
      n_bad++;
      $display("[TB] FAIL slice_prev: got out=%0h widx=%0d sidx=%0d reads=%0d, expected dead/0/1/2",
               out32, widx32, sidx32, rd32 - rd0);
    end
  endtask

  // Random walk over the 3-word, 2-slice region against a position model.
  task automatic test_random;
    int w, s, op, rd0;
    bit fetch;
    logic [31:0] word;
    logic [15:0] exp_out;
    for (int i = 0; i < 3; i++) mem32[i] = $urandom;
    do_start(1'b1);
    w = 0;
    s = 0;
    for (int k = 0; k < 24; k++) begin
      op = $urandom_range(0, 2);
      fetch = 1'b0;
      rd0 = rd32;
      if (op == 0) begin
        press(1'b1, 1'b1, 1'b0, 20);
        if (s < 1) s = s + 1;
        else begin s = 0; w = (w + 1) % 3; fetch = 1'b1; end
      end else if (op == 1) begin
        press(1'b1, 1'b0, 1'b1, 20);
        if (s > 0) s = s - 1;
        else begin s = 1; w = (w + 2) % 3; fetch = 1'b1; end
      end else begin
        press(1'b1, 1'b1, 1'b1, 20);
      end
      word = mem32[w];
      exp_out = 16'(word >> (16 * s));
      n_cmp++;
      if (out32 !== exp_out || widx32 !== 10'(w) || sidx32 !== 8'(s) || rd32 - rd0 !== int'(fetch)) begin
        n_bad++;
        $display("[TB] FAIL random%0d op=%0d: got out=%0h widx=%0d sidx=%0d reads=%0d, expected %0h/%0d/%0d/%0d",
                 k, op, out32, widx32, sidx32, rd32 - rd0, exp_out, w, s, fetch);
      end
    end
  endtask

  // No memory response: 1 FETCH cycle plus 16 WAIT cycles of busy.
  task automatic test_timeout;
    int nbusy;
    mem16_en = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    tick(4);
    start16 = 1'b1;
    for (int i = 0; i < 20 && busy16 !== 1'b1; i++) tick(1);
    nbusy = 0;
    while (busy16 === 1'b1 && nbusy < 40) begin
      nbusy++;
      tick(1);
    end
    n_cmp++;
    if (nbusy !== 17) begin
      n_bad++;
      $display("[TB] FAIL timeout_busy: got %0d busy cycles, expected 17", nbusy);
    end
    n_cmp++;
    if (err16 !== 1'b1 || out16 !== 16'hFFFF) begin
      n_bad++;
      $display("[TB] FAIL timeout_err: got err=%0b out=%0h, expected err=1 out=ffff", err16, out16);
    end
    mem16_en = 1'b1;
    do_start(1'b0);
    n_cmp++;
    if (err16 !== 1'b0 || out16 !== 16'd7 || widx16 !== 10'd0) begin
      n_bad++;
      $display("[TB] FAIL err_clear: got err=%0b out=%0h widx=%0d, expected 0/7/0", err16, out16, widx16);
    end
  endtask

  task automatic test_reset_mid_wait;
    int rd0;
    mem16_en = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    tick(4);
    start16 = 1'b1;
    for (int i = 0; i < 20 && busy16 !== 1'b1; i++) tick(1);
    tick(3);
    rst = 1'b0;
    start16 = 1'b0;
    start32 = 1'b0;
    #1;
    n_cmp++;
    if ({out16, widx16, sidx16, busy16, err16, bus16.mem_rd_en, bus16.mem_addr} !==
        {16'd0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 10'd100}) begin
      n_bad++;
      $display("[TB] FAIL reset_wait: got out=%0h widx=%0d sidx=%0d busy=%0b err=%0b rd=%0b addr=%0d, expected zeros with addr=100",
               out16, widx16, sidx16, busy16, err16, bus16.mem_rd_en, bus16.mem_addr);
    end
    tick(2);
    rst = 1'b1;
    mem16_en = 1'b1;
    tick(2);
    inj16_data = 16'h1234;
    inj16_valid = 1'b1;
    tick(1);
    inj16_valid = 1'b0;
    tick(3);
    n_cmp++;
    if (busy16 !== 1'b0 || out16 !== 16'd0 || err16 !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL late_valid: got busy=%0b out=%0h err=%0b, expected 0/0/0", busy16, out16, err16);
    end
    rd0 = rd16;
    press(1'b0, 1'b1, 1'b0, 20);
    n_cmp++;
    if (widx16 !== 10'd0 || out16 !== 16'd0 || rd16 != rd0) begin
      n_bad++;
      $display("[TB] FAIL idle_button: got widx=%0d out=%0h reads=%0d, expected 0/0/0", widx16, out16, rd16 - rd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem16[i] = 16'h5A5A;
      mem32[i] = 32'hA5A5_5A5A;
    end
    mem16[100] = 16'd7;
    mem16[101] = 16'd3;
    mem16[102] = 16'd9;
    mem16[103] = 16'd1;

    test_reset;
    test_start_latency;
    test_next_wrap;
    test_prev_wrap;
    test_bounce;
    test_slices;
    test_random;
    test_timeout;
    test_reset_mid_wait;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
